// File: rtl/i2s_tx_serializer.sv
// I2S master transmitter: divides sys_clk into bclk/lrclk and shifts one stereo
// pair per frame out MSB-first, one bclk after each word-select edge.
module i2s_tx_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  tx_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_left,
    input  logic [DATA_WIDTH-1:0] in_right,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_data,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_DATA_LAST = BIT_W'(DATA_WIDTH);

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

    logic [DIV_W-1:0]      div_q, div_d;
    logic                  bclk_q, bclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  data_q, data_d;
    slot_e                 slot_q, slot_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  frame_start_q, frame_start_d;
    logic                  underrun_q, underrun_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
    logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;
    logic [DATA_WIDTH-1:0] shift_left_q, shift_left_d;
    logic [DATA_WIDTH-1:0] shift_right_q, shift_right_d;

    logic fall;
    logic frame_load;
    logic accept;
    logic in_data_bits;

    always_comb begin
        fall         = tx_en && bclk_q && (div_q == DIV_LAST);
        frame_load   = fall && (slot_q == SLOT_LEFT) && (bit_q == '0);
        accept       = in_valid && !hold_full_q;
        in_data_bits = (bit_q != '0) && (bit_q <= BIT_DATA_LAST);
    end

    // Bit-clock generation and serialization; everything idles while tx_en is low.
    always_comb begin
        div_d         = div_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        data_d        = data_q;
        slot_d        = slot_q;
        bit_d         = bit_q;
        shift_left_d  = shift_left_q;
        shift_right_d = shift_right_q;

        if (!tx_en) begin
            div_d         = '0;
            bclk_d        = 1'b0;
            lrclk_d       = 1'b1;
            data_d        = 1'b0;
            slot_d        = SLOT_LEFT;
            bit_d         = '0;
            shift_left_d  = '0;
            shift_right_d = '0;
        end else begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                bclk_d = !bclk_q;
            end else begin
                div_d = div_q + DIV_W'(1);
            end

            if (fall) begin
                lrclk_d = (slot_q == SLOT_RIGHT);
                data_d  = 1'b0;
                if (bit_q == BIT_LAST) begin
                    bit_d  = '0;
                    slot_d = (slot_q == SLOT_LEFT) ? SLOT_RIGHT : SLOT_LEFT;
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end

                // Slot bit 0 is the WS-delay bit; bits past DATA_WIDTH pad with zeros.
                if (in_data_bits) begin
                    if (slot_q == SLOT_LEFT) begin
                        data_d       = shift_left_q[DATA_WIDTH-1];
                        shift_left_d = shift_left_q << 1;
                    end else begin
                        data_d        = shift_right_q[DATA_WIDTH-1];
                        shift_right_d = shift_right_q << 1;
                    end
                end
            end

            if (frame_load) begin
                if (hold_full_q) begin
                    shift_left_d  = hold_left_q;
                    shift_right_d = hold_right_q;
                end else begin
                    shift_left_d  = '0;
                    shift_right_d = '0;
                end
            end
        end
    end

    // Holding register: a pair arriving on the load edge itself waits for the next frame.
    always_comb begin
        hold_full_d   = hold_full_q;
        hold_left_d   = hold_left_q;
        hold_right_d  = hold_right_q;
        frame_start_d = frame_load;
        underrun_d    = frame_load && !hold_full_q;

        if (frame_load && hold_full_q) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d  = 1'b1;
            hold_left_d  = in_left;
            hold_right_d = in_right;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q         <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b1;
            data_q        <= 1'b0;
            slot_q        <= SLOT_LEFT;
            bit_q         <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            hold_full_q   <= 1'b0;
            hold_left_q   <= '0;
            hold_right_q  <= '0;
            shift_left_q  <= '0;
            shift_right_q <= '0;
        end else begin
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            lrclk_q       <= lrclk_d;
            data_q        <= data_d;
            slot_q        <= slot_d;
            bit_q         <= bit_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_full_q   <= hold_full_d;
            hold_left_q   <= hold_left_d;
            hold_right_q  <= hold_right_d;
            shift_left_q  <= shift_left_d;
            shift_right_q <= shift_right_d;
        end
    end

    assign in_ready    = !hold_full_q;
    assign i2s_bclk    = bclk_q;
    assign i2s_lrclk   = lrclk_q;
    assign i2s_data    = data_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Testbench for i2s_tx_serializer: a bclk-rising-edge sampler recovers whole frames
// and compares them with a queue-based model of accepted stereo pairs.
module tb_i2s_tx_serializer;

   localparam int DW = 24;
   localparam int SW = 32;
   localparam int BD = 2;
   localparam int FRAME_CYCLES = 2 * SW * 2 * BD;
   localparam logic [63:0] LR_EXP = {32'hFFFF_FFFF, 32'h0000_0000};

   logic sysClk = 1'b0;
   logic sysRstN;
   logic txEn;
   logic inValid;
   logic inReady;
   logic [DW-1:0] inLeft;
   logic [DW-1:0] inRight;
   logic bclk;
   logic lrclk;
   logic data;
   logic frameStart;
   logic underrun;

   i2s_tx_serializer #(
      .DATA_WIDTH(DW),
      .SLOT_WIDTH(SW),
      .BCLK_DIV  (BD)
   ) dut (
      .sys_clk    (sysClk),
      .sys_rst_n  (sysRstN),
      .tx_en      (txEn),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_left    (inLeft),
      .in_right   (inRight),
      .i2s_bclk   (bclk),
      .i2s_lrclk  (lrclk),
      .i2s_data   (data),
      .frame_start(frameStart),
      .underrun   (underrun)
   );

   // 10 ns system clock
   always #5 sysClk = ~sysClk;

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      int            stamp;
   } pair_t;

   typedef struct {
      logic [63:0] gotBits;
      logic [63:0] gotLr;
      logic [63:0] expBits;
      logic        gotUnder;
      logic        expUnder;
      int          startCyc;
      int          periodErr;
   } frame_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   pair_t  modelQ[$];
   frame_t frameQ[$];
   frame_t cur;
   bit     capturing = 1'b0;
   int     bitIdx = 0;
   int     lastRise = 0;
   logic   prevBclk = 1'b0;

   // Expected serial stream of one frame, straight from the slot layout rules
   function automatic logic [63:0] frameBits(input logic [DW-1:0] l, input logic [DW-1:0] r);
      logic [63:0] b;
      logic [DW-1:0] w;
      int p;
      b = '0;
      for (int k = 0; k < 2 * SW; k++) begin
         p = k % SW;
         w = (k >= SW) ? r : l;
         if (p >= 1 && p <= DW) b[k] = w[DW-p];
      end
      return b;
   endfunction

   function automatic logic [DW-1:0] slotWord(input logic [63:0] b, input int base);
      logic [DW-1:0] w;
      w = '0;
      for (int p = 1; p <= DW; p++) w[DW-p] = b[base+p];
      return w;
   endfunction

   function automatic logic [63:0] padMask();
      logic [63:0] m;
      int p;
      m = '0;
      for (int k = 0; k < 2 * SW; k++) begin
         p = k % SW;
         if (!(p >= 1 && p <= DW)) m[k] = 1'b1;
      end
      return m;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sysClk);
      #1;
   endtask

   // Offer a pair and hold it until the handshake completes (bounded wait)
   task automatic applyStimulus(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r);
      int budget;
      budget = 0;
      while (inReady !== 1'b1 && budget < 400) begin
         tick(1);
         budget++;
      end
      checkOutput({tag, "_readyToAccept"}, 64'(inReady), 64'd1);
      inLeft  = l;
      inRight = r;
      inValid = 1'b1;
      tick(1);
      inValid = 1'b0;
   endtask

   // Pop the oldest captured frame and compare it with the model's expectation
   task automatic expectFrame(input string tag, output frame_t f);
      int budget;
      budget = 0;
      while (frameQ.size() == 0 && budget < 400) begin
         @(negedge sysClk);
         #1;
         budget++;
      end
      checkOutput({tag, "_arrived"}, 64'(frameQ.size() != 0), 64'd1);
      if (frameQ.size() != 0) begin
         f = frameQ.pop_front();
      end else begin
         f.gotBits = '1; f.gotLr = '1; f.expBits = '0;
         f.gotUnder = 1'bx; f.expUnder = 1'b0; f.startCyc = 0; f.periodErr = 1;
      end
      checkOutput({tag, "_bits"}, f.gotBits, f.expBits);
      checkOutput({tag, "_lrclk"}, f.gotLr, LR_EXP);
      checkOutput({tag, "_underrun"}, 64'(f.gotUnder), 64'(f.expUnder));
      checkOutput({tag, "_bclkPeriod"}, 64'(f.periodErr), 64'd0);
      @(posedge sysClk);
      #1;
   endtask

   // Monitor on the falling sys_clk edge: handshake model, pulse checks and frame sampler
   always @(negedge sysClk) begin
      pair_t np;
      bit    elig;
      cyc++;
      if (!sysRstN) begin
         capturing = 1'b0;
         prevBclk  = 1'b0;
         modelQ.delete();
      end else begin
         if (frameStart === 1'b1) begin
            elig = (modelQ.size() > 0) && (modelQ[0].stamp <= cyc - 2);
            cur.expUnder = !elig;
            if (elig) begin
               np = modelQ.pop_front();
               cur.expBits = frameBits(np.l, np.r);
            end else begin
               cur.expBits = '0;
            end
            cur.gotBits   = '0;
            cur.gotLr     = '0;
            cur.gotUnder  = underrun;
            cur.startCyc  = cyc;
            cur.periodErr = 0;
            capturing     = 1'b1;
            bitIdx        = 0;
            checkOutput("underrunPulse", 64'(underrun), 64'(!elig));
         end else begin
            checkOutput("underrunIdle", 64'(underrun), 64'd0);
         end
         checkOutput("inReadyModel", 64'(inReady), 64'(modelQ.size() == 0));
         if (txEn !== 1'b1) capturing = 1'b0;
         if (capturing && prevBclk === 1'b0 && bclk === 1'b1) begin
            cur.gotBits[bitIdx] = data;
            cur.gotLr[bitIdx]   = lrclk;
            if (bitIdx > 0 && (cyc - lastRise) != 2 * BD) cur.periodErr++;
            lastRise = cyc;
            bitIdx++;
            if (bitIdx == 2 * SW) begin
               frameQ.push_back(cur);
               capturing = 1'b0;
            end
         end
         prevBclk = bclk;
         if (inValid === 1'b1 && inReady === 1'b1) begin
            np.l = inLeft;
            np.r = inRight;
            np.stamp = cyc;
            modelQ.push_back(np);
         end
      end
   end

   // Watchdog so a stuck run still terminates
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence of test phases
   initial begin
      frame_t f, g;
      logic [63:0] pad;
      logic [DW-1:0] rl[4];
      logic [DW-1:0] rr[4];
      int enCyc;

      pad = padMask();
      sysRstN = 1'b0; txEn = 1'b0; inValid = 1'b0; inLeft = '0; inRight = '0;
      tick(3);
      checkOutput("rstBclk", 64'(bclk), 64'd0);
      checkOutput("rstLrclk", 64'(lrclk), 64'd1);
      checkOutput("rstData", 64'(data), 64'd0);
      checkOutput("rstFrameStart", 64'(frameStart), 64'd0);
      checkOutput("rstUnderrun", 64'(underrun), 64'd0);
      checkOutput("rstReady", 64'(inReady), 64'd1);
      sysRstN = 1'b1;
      tick(2);

      // Basic frame followed by an underrun frame
      applyStimulus("basic", 24'hA5A5A5, 24'h5A5A5A);
      checkOutput("basicReadyLow", 64'(inReady), 64'd0);
      tick(3);
      checkOutput("basicHeldWhileIdle", 64'(inReady), 64'd0);
      enCyc = cyc;
      txEn = 1'b1;
      expectFrame("basic", f);
      checkOutput("basicStartLatency", 64'(f.startCyc), 64'(enCyc + 2 * BD + 1));
      checkOutput("basicLeft", 64'(slotWord(f.gotBits, 0)), 64'h A5A5A5);
      checkOutput("basicRight", 64'(slotWord(f.gotBits, SW)), 64'h 5A5A5A);
      checkOutput("basicPadZero", f.gotBits & pad, 64'd0);
      checkOutput("basicNoUnderrun", 64'(f.gotUnder), 64'd0);
      expectFrame("underrun", g);
      checkOutput("underrunFlag", 64'(g.gotUnder), 64'd1);
      checkOutput("underrunZeroData", g.gotBits, 64'd0);
      checkOutput("lrclkPeriod", 64'(g.startCyc - f.startCyc), 64'(FRAME_CYCLES));
      txEn = 1'b0;
      tick(4);

      // Back-to-back streaming of two pairs
      applyStimulus("streamA", 24'h000001, 24'h800000);
      checkOutput("streamReadyLow", 64'(inReady), 64'd0);
      txEn = 1'b1;
      applyStimulus("streamB", 24'h7FFFFF, 24'h123456);
      checkOutput("streamBReadyLow", 64'(inReady), 64'd0);
      expectFrame("streamA", f);
      expectFrame("streamB", g);
      checkOutput("streamALeft", 64'(slotWord(f.gotBits, 0)), 64'h000001);
      checkOutput("streamARight", 64'(slotWord(f.gotBits, SW)), 64'h800000);
      checkOutput("streamBLeft", 64'(slotWord(g.gotBits, 0)), 64'h7FFFFF);
      checkOutput("streamBRight", 64'(slotWord(g.gotBits, SW)), 64'h123456);
      checkOutput("streamNoUnderrun", 64'({f.gotUnder, g.gotUnder}), 64'd0);
      checkOutput("streamSpacing", 64'(g.startCyc - f.startCyc), 64'(FRAME_CYCLES));
      txEn = 1'b0;
      tick(4);

      // Randomized streaming
      for (int i = 0; i < 4; i++) begin
         rl[i] = DW'($urandom);
         rr[i] = DW'($urandom);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus("random", rl[i], rr[i]);
         if (i == 0) txEn = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         expectFrame("random", f);
         checkOutput("randomLeft", 64'(slotWord(f.gotBits, 0)), 64'(rl[i]));
         checkOutput("randomRight", 64'(slotWord(f.gotBits, SW)), 64'(rr[i]));
         checkOutput("randomNoUnderrun", 64'(f.gotUnder), 64'd0);
      end
      txEn = 1'b0;
      tick(4);

      // Pair offered exactly on the first frame-load edge
      txEn = 1'b1;
      tick(3);
      checkOutput("boundaryReady", 64'(inReady), 64'd1);
      inLeft = 24'h3C3C3C; inRight = 24'hC3C3C3; inValid = 1'b1;
      tick(1);
      inValid = 1'b0;
      expectFrame("boundaryZero", f);
      checkOutput("boundaryUnderrun", 64'(f.gotUnder), 64'd1);
      checkOutput("boundaryZeroData", f.gotBits, 64'd0);
      expectFrame("boundaryNext", g);
      checkOutput("boundaryNextLeft", 64'(slotWord(g.gotBits, 0)), 64'h3C3C3C);
      checkOutput("boundaryNextRight", 64'(slotWord(g.gotBits, SW)), 64'hC3C3C3);
      txEn = 1'b0;
      tick(4);

      // tx_en dropped just after the pos=40 fall event, then re-enabled
      applyStimulus("dropFirst", 24'h111111, 24'h010000);
      enCyc = cyc;
      txEn = 1'b1;
      applyStimulus("dropHeld", 24'hBEEF01, 24'h0FACE0);
      while (cyc < enCyc + 2 * BD + 40 * 2 * BD + BD) tick(1);
      checkOutput("preDropBclk", 64'(bclk), 64'd1);
      checkOutput("preDropLrclk", 64'(lrclk), 64'd1);
      checkOutput("preDropData", 64'(data), 64'd1);
      txEn = 1'b0;
      tick(1);
      checkOutput("dropBclk", 64'(bclk), 64'd0);
      checkOutput("dropLrclk", 64'(lrclk), 64'd1);
      checkOutput("dropData", 64'(data), 64'd0);
      checkOutput("dropHeldReady", 64'(inReady), 64'd0);
      tick(3);
      enCyc = cyc;
      txEn = 1'b1;
      expectFrame("reEnable", f);
      checkOutput("reEnableLatency", 64'(f.startCyc), 64'(enCyc + 2 * BD + 1));
      checkOutput("reEnableFirstLr", 64'(f.gotLr[0]), 64'd0);
      checkOutput("reEnableLeft", 64'(slotWord(f.gotBits, 0)), 64'hBEEF01);
      checkOutput("reEnableRight", 64'(slotWord(f.gotBits, SW)), 64'h0FACE0);

      // Asynchronous reset in the middle of a frame with a pair pending
      tick(8);
      applyStimulus("rstPending", 24'h777777, 24'h888888);
      tick(20);
      checkOutput("preResetReady", 64'(inReady), 64'd0);
      #3;
      sysRstN = 1'b0;
      #1;
      checkOutput("asyncRstBclk", 64'(bclk), 64'd0);
      checkOutput("asyncRstLrclk", 64'(lrclk), 64'd1);
      checkOutput("asyncRstData", 64'(data), 64'd0);
      checkOutput("asyncRstFrameStart", 64'(frameStart), 64'd0);
      checkOutput("asyncRstUnderrun", 64'(underrun), 64'd0);
      checkOutput("asyncRstReady", 64'(inReady), 64'd1);
      modelQ.delete();
      txEn = 1'b0;
      tick(2);
      sysRstN = 1'b1;
      tick(2);
      txEn = 1'b1;
      expectFrame("afterReset", f);
      checkOutput("afterResetUnderrun", 64'(f.gotUnder), 64'd1);
      checkOutput("afterResetZeroData", f.gotBits, 64'd0);
      txEn = 1'b0;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
